cpu_decode_exec: RTL and testbench

- Registered decode-and-execute stage of the 32-bit MIPS-subset CPU.
- Takes the fetched instruction and the two register-file read values.
- Combinationally performs main decode (opcode → control), ALU-control decode (alu_op + funct → alu_ctr) and the ALU operation.
- Registers the control bundle, destination address, ALU result and zero flag on the rising clock edge for the memory/write-back stage.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/cpu_alu.sv | 35 +++
 rtl/cpu_decode_exec.sv | 148 ++++++++++++++
 tb/tb_cpu_decode_exec.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the decode/execute stage: opcodes, functs, alu_op/alu_ctr codes, control bundle.
// The optional shift operations are enabled with the CPU_SHIFT_EN macro (see cpu_decode_exec).
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_NOP   = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_NOR = 4'b1100,
    ALU_INV = 4'b1111
  } alu_ctr_e;

  typedef struct packed {
    logic    reg_dst;
    logic    reg_wrt;
    logic    alu_src;
    logic    mem_reg;
    logic    mem_read;
    logic    mem_wrt;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: alu_ctr selects the operation on a/b (shamt for shifts); invalid codes give 0.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_ctr_e          alu_ctr,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [4:0]        shamt,
  output logic [XLEN-1:0]   result,
  output logic              zero
);

  logic lt;
  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (alu_ctr)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_decode_exec.sv
// Registered decode/execute stage: main decode, ALU-control decode and ALU, one instruction per cycle.
// Define CPU_SHIFT_EN to decode R-type sll/srl; otherwise those functs are invalid.
module cpu_decode_exec
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_out,
  output logic            zf,
  output logic            branch_taken,
  output logic            reg_wrt,
  output logic            mem_read,
  output logic            mem_wrt,
  output logic            mem_reg,
  output logic [4:0]      addr_dst,
  output logic [XLEN-1:0] store_data
);

`ifdef CPU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  function automatic ctrl_t main_decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    c.alu_op = ALUOP_NOP;
    case (op)
      OP_RTYPE: begin
        c.reg_dst = 1'b1;
        c.reg_wrt = 1'b1;
        c.alu_op  = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.reg_wrt  = 1'b1;
        c.alu_src  = 1'b1;
        c.mem_reg  = 1'b1;
        c.mem_read = 1'b1;
        c.alu_op   = ALUOP_ADD;
      end
      OP_SW: begin
        c.alu_src = 1'b1;
        c.mem_wrt = 1'b1;
        c.alu_op  = ALUOP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        c.reg_wrt = 1'b1;
        c.alu_src = 1'b1;
        c.alu_op  = ALUOP_ADD;
      end
      default: c.alu_op = ALUOP_NOP;
    endcase
    return c;
  endfunction

  function automatic alu_ctr_e alu_decode(input alu_op_e alu_op, input logic [5:0] funct);
    alu_ctr_e r;
    r = ALU_INV;
    case (alu_op)
      ALUOP_ADD: r = ALU_ADD;
      ALUOP_SUB: r = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   r = ALU_ADD;
          F_SUB:   r = ALU_SUB;
          F_AND:   r = ALU_AND;
          F_OR:    r = ALU_OR;
          F_NOR:   r = ALU_NOR;
          F_SLT:   r = ALU_SLT;
          F_SLL:   r = SHIFT_EN ? ALU_SLL : ALU_INV;
          F_SRL:   r = SHIFT_EN ? ALU_SRL : ALU_INV;
          default: r = ALU_INV;
        endcase
      end
      default: r = ALU_INV;
    endcase
    return r;
  endfunction

  ctrl_t           ctrl;
  alu_ctr_e        alu_ctr;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            wrt_en;
  logic            unused_rs_field;

  // rs is resolved by the register file upstream; only its value arrives here.
  assign unused_rs_field = ^inst[25:21];

  always_comb begin
    ctrl      = main_decode(inst[31:26]);
    alu_ctr   = alu_decode(ctrl.alu_op, inst[5:0]);
    imm_ext   = {{(XLEN-16){inst[15]}}, inst[15:0]};
    operand_b = ctrl.alu_src ? imm_ext : rt_data;
    wrt_en    = ctrl.reg_wrt && !((ctrl.alu_op == ALUOP_FUNCT) && (alu_ctr == ALU_INV));
  end

  cpu_alu #(.XLEN(XLEN)) u_alu (
    .alu_ctr (alu_ctr),
    .a       (rs_data),
    .b       (operand_b),
    .shamt   (inst[10:6]),
    .result  (result),
    .zero    (zero)
  );

  // Side-effecting strobes are qualified by in_valid; data fields just follow the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      alu_out      <= '0;
      zf           <= 1'b0;
      branch_taken <= 1'b0;
      reg_wrt      <= 1'b0;
      mem_read     <= 1'b0;
      mem_wrt      <= 1'b0;
      mem_reg      <= 1'b0;
      addr_dst     <= '0;
      store_data   <= '0;
    end else begin
      out_valid    <= in_valid;
      alu_out      <= result;
      zf           <= zero;
      branch_taken <= in_valid & ctrl.branch & zero;
      reg_wrt      <= in_valid & wrt_en;
      mem_read     <= in_valid & ctrl.mem_read;
      mem_wrt      <= in_valid & ctrl.mem_wrt;
      mem_reg      <= ctrl.mem_reg;
      addr_dst     <= ctrl.reg_dst ? inst[15:11] : inst[20:16];
      store_data   <= rt_data;
    end
  end

endmodule

// File: tb/tb_cpu_decode_exec.sv
// Table-driven bench for cpu_decode_exec with a scoreboard queue of expected stage outputs.
// Shift expectations follow CPU_SHIFT_EN so the same bench covers both builds.
module tb_cpu_decode_exec;

`ifdef CPU_SHIFT_EN
  localparam bit SHIFT = 1'b1;
`else
  localparam bit SHIFT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst, rs_data, rt_data;
  logic        out_valid, zf, branch_taken, reg_wrt, mem_read, mem_wrt, mem_reg;
  logic [31:0] alu_out, store_data;
  logic [4:0]  addr_dst;

  cpu_decode_exec dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .inst         (inst),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .out_valid    (out_valid),
    .alu_out      (alu_out),
    .zf           (zf),
    .branch_taken (branch_taken),
    .reg_wrt      (reg_wrt),
    .mem_read     (mem_read),
    .mem_wrt      (mem_wrt),
    .mem_reg      (mem_reg),
    .addr_dst     (addr_dst),
    .store_data   (store_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] inst, rs, rt;
    logic        e_valid, e_rw, e_mr, e_mw, e_mreg, e_bt, e_zf;
    logic [4:0]  e_ad;
    logic [31:0] e_ao, e_sd;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   passed = 0;

  function automatic vec_t mk(string n, logic v, logic [31:0] i, logic [31:0] rs, logic [31:0] rt,
                              logic rw, logic mr, logic mw, logic mreg, logic bt, logic z,
                              logic [4:0] ad, logic [31:0] ao, logic chk);
    vec_t t;
    t.name = n; t.v = v; t.inst = i; t.rs = rs; t.rt = rt;
    t.e_valid = v; t.e_rw = rw; t.e_mr = mr; t.e_mw = mw; t.e_mreg = mreg; t.e_bt = bt;
    t.e_zf = z; t.e_ad = ad; t.e_ao = ao; t.e_sd = rt; t.chk_data = chk;
    return t;
  endfunction

  task automatic check(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", n, f, act, exp);
  endtask

  task automatic applyStimulus(input vec_t t, input bit push);
    in_valid = t.v;
    inst     = t.inst;
    rs_data  = t.rs;
    rt_data  = t.rt;
    if (push) sb.push_back(t);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      check("scoreboard", "empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check(e.name, "out_valid", {31'b0, out_valid}, {31'b0, e.e_valid});
    check(e.name, "reg_wrt", {31'b0, reg_wrt}, {31'b0, e.e_rw});
    check(e.name, "mem_read", {31'b0, mem_read}, {31'b0, e.e_mr});
    check(e.name, "mem_wrt", {31'b0, mem_wrt}, {31'b0, e.e_mw});
    check(e.name, "branch_taken", {31'b0, branch_taken}, {31'b0, e.e_bt});
    if (e.chk_data) begin
      check(e.name, "alu_out", alu_out, e.e_ao);
      check(e.name, "zf", {31'b0, zf}, {31'b0, e.e_zf});
      check(e.name, "mem_reg", {31'b0, mem_reg}, {31'b0, e.e_mreg});
      check(e.name, "addr_dst", {27'b0, addr_dst}, {27'b0, e.e_ad});
      check(e.name, "store_data", store_data, e.e_sd);
    end
  endtask

  task automatic checkZero(input string n);
    check(n, "out_valid", {31'b0, out_valid}, 32'd0);
    check(n, "alu_out", alu_out, 32'd0);
    check(n, "zf", {31'b0, zf}, 32'd0);
    check(n, "branch_taken", {31'b0, branch_taken}, 32'd0);
    check(n, "reg_wrt", {31'b0, reg_wrt}, 32'd0);
    check(n, "mem_read", {31'b0, mem_read}, 32'd0);
    check(n, "mem_wrt", {31'b0, mem_wrt}, 32'd0);
    check(n, "mem_reg", {31'b0, mem_reg}, 32'd0);
    check(n, "addr_dst", {27'b0, addr_dst}, 32'd0);
    check(n, "store_data", store_data, 32'd0);
  endtask

  initial begin
    //               name        v  inst          rs            rt            rw mr mw mg bt zf ad  alu_out       chk
    vecs.push_back(mk("add",      1, 32'h00221820, 32'd5,        32'd7,        1, 0, 0, 0, 0, 0, 3, 32'd12,       1));
    vecs.push_back(mk("sub_eq",   1, 32'h00222022, 32'd9,        32'd9,        1, 0, 0, 0, 0, 1, 4, 32'd0,        1));
    vecs.push_back(mk("slt_neg",  1, 32'h0022282A, 32'hFFFFFFFF, 32'd1,        1, 0, 0, 0, 0, 0, 5, 32'd1,        1));
    vecs.push_back(mk("slt_pos",  1, 32'h0022282A, 32'd1,        32'hFFFFFFFF, 1, 0, 0, 0, 0, 1, 5, 32'd0,        1));
    vecs.push_back(mk("and",      1, 32'h00223024, 32'h0000F0F0, 32'h0000FF00, 1, 0, 0, 0, 0, 0, 6, 32'h0000F000, 1));
    vecs.push_back(mk("or",       1, 32'h00223825, 32'h0000F0F0, 32'h00000F0F, 1, 0, 0, 0, 0, 0, 7, 32'h0000FFFF, 1));
    vecs.push_back(mk("nor",      1, 32'h00224027, 32'd0,        32'hFFFF0000, 1, 0, 0, 0, 0, 0, 8, 32'h0000FFFF, 1));
    vecs.push_back(mk("add_wrap", 1, 32'h00221820, 32'hFFFFFFFF, 32'd1,        1, 0, 0, 0, 0, 1, 3, 32'd0,        1));
    vecs.push_back(mk("lw",       1, 32'h8C22FFFC, 32'h00000100, 32'h0000DEAD, 1, 1, 0, 1, 0, 0, 2, 32'h000000FC, 1));
    vecs.push_back(mk("sw",       1, 32'hAC220008, 32'h00000200, 32'h12345678, 0, 0, 1, 0, 0, 0, 2, 32'h00000208, 1));
    vecs.push_back(mk("beq_tk",   1, 32'h10220004, 32'h55,       32'h55,       0, 0, 0, 0, 1, 1, 2, 32'd0,        1));
    vecs.push_back(mk("beq_nt",   1, 32'h10220004, 32'h55,       32'h54,       0, 0, 0, 0, 0, 0, 2, 32'd1,        1));
    vecs.push_back(mk("addi",     1, 32'h2022FFFF, 32'd5,        32'd99,       1, 0, 0, 0, 0, 0, 2, 32'd4,        1));
    vecs.push_back(mk("op_3f",    1, 32'hFC221820, 32'd5,        32'd7,        0, 0, 0, 0, 0, 1, 2, 32'd0,        1));
    vecs.push_back(mk("funct_3f", 1, 32'h0022183F, 32'd5,        32'd7,        0, 0, 0, 0, 0, 1, 3, 32'd0,        1));
    vecs.push_back(mk("sw_inval", 0, 32'hAC220008, 32'h00000200, 32'h12345678, 0, 0, 0, 0, 0, 0, 2, 32'd0,        0));
    vecs.push_back(mk("sll",      1, 32'h00021900, 32'h0000ABCD, 32'd1,        SHIFT, 0, 0, 0, 0, !SHIFT, 3,
                      SHIFT ? 32'h10 : 32'h0, 1));
    vecs.push_back(mk("srl",      1, 32'h00021FC2, 32'h0000ABCD, 32'h80000000, SHIFT, 0, 0, 0, 0, !SHIFT, 3,
                      SHIFT ? 32'h1 : 32'h0, 1));
    vecs.push_back(mk("nop_zero", 1, 32'h00000000, 32'd0,        32'd0,        SHIFT, 0, 0, 0, 0, 1, 0, 32'd0,        1));

    rst_n = 1'b0;
    in_valid = 1'b0; inst = '0; rs_data = '0; rt_data = '0;
    #12;
    checkZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream: one instruction per cycle, checked #1 after each edge.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k], 1'b1);
      @(posedge clk);
      #1;
      checkOutput();
    end

    // Reset asserted between edges clears outputs at once and holds them until the first edge after release.
    applyStimulus(vecs[8], 1'b1);
    @(posedge clk);
    #1;
    checkOutput();
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("rst_async");
    applyStimulus(vecs[0], 1'b0);
    @(posedge clk);
    #1;
    checkZero("rst_hold");
    #2;
    rst_n = 1'b1;
    #1;
    checkZero("rst_release");
    applyStimulus(vecs[9], 1'b1);
    @(posedge clk);
    #1;
    checkOutput();

    check("scoreboard", "drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
